count_compare_pwm: RTL
======================

# count_compare_pwm

Downstream consumer of the 4-bit free-running binary counter. It samples the counter value every clock and produces four things:
- a glitch-free PWM output, with the duty cycle reloaded only at the counter's 15→0 wrap;
- a wrap pulse and an epoch (wrap) counter;
- a sticky sequence-error flag for non-consecutive counter values;
- a one-slot capture register read out over a valid/ready handshake.

## Interface
- EPOCH_W, 8, width of the wrap (epoch) counter; legal range 1..16.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- count  in  4  counter value from the upstream binary counter, same clock domain.
- duty  in  4  requested PWM duty in sixteenths (0..15).
- duty_load  in  1  one-cycle strobe; latches duty into the pending register.
- err_clr  in  1  clears seq_err.
- capture_req  in  1  one-cycle request to snapshot count/epoch.
- cap_ready  in  1  consumer ready for the capture slot.
- pwm_out  out  1  registered PWM output.
- wrap_pulse  out  1  one-cycle pulse per detected 15→0 transition.
- epoch  out  EPOCH_W  number of wraps since reset, modulo 2^EPOCH_W.
- seq_err  out  1  sticky: the counter skipped or repeated a value.
- cap_valid  out  1  capture slot holds data.
- cap_count  out  4  captured count.
- cap_epoch  out  EPOCH_W  captured epoch.
- cap_drop  out  1  one-cycle pulse: capture_req lost because the slot was full.

## Operation
- **Reset values.** On reset all registers clear:
  - outputs pwm_out, wrap_pulse, epoch, seq_err, cap_valid, cap_count, cap_epoch and cap_drop are 0;
  - internal count_q, prev_valid, duty_pend, pend_flag and duty_act are 0.
- **Sampling.** count_q <= count every cycle. prev_valid is set to 1 on the first cycle after reset deasserts.
- **Wrap detection.** wrap = prev_valid & (count_q == 15) & (count == 0).
  - wrap_pulse <= wrap.
  - On wrap, epoch <= epoch + 1, wrapping modulo 2^EPOCH_W with no saturation.
- **Sequence check.** If prev_valid and count != (count_q + 1) mod 16, seq_err <= 1.
  - seq_err holds until err_clr or reset.
  - If a new error and err_clr occur in the same cycle, the error wins and seq_err stays 1.
- **Duty shadowing.**
  - duty_load sets duty_pend <= duty and pend_flag <= 1. A later duty_load before the wrap overwrites duty_pend (last one wins).
  - On wrap with pend_flag = 1: duty_act <= duty_pend and pend_flag <= 0.
  - If duty_load coincides with wrap, the old duty_pend is applied and the new value becomes pending.
- **PWM.** pwm_out <= (count < duty_eff), where duty_eff = duty_pend when (wrap & pend_flag), else duty_act.
  - duty 0 means pwm_out is always 0.
  - duty 15 means pwm_out is high 15 of every 16 cycles.
- **Capture slot.** Two states, EMPTY (cap_valid = 0) and FULL (cap_valid = 1).
  - EMPTY, capture_req: cap_count <= count, cap_epoch <= epoch + wrap (the epoch value after this cycle's update), go to FULL.
  - FULL, cap_ready: go to EMPTY. If capture_req arrives in the same cycle, reload the slot and stay FULL.
  - FULL, capture_req without cap_ready: request discarded, cap_drop <= 1 for one cycle, slot contents unchanged.
  - cap_count and cap_epoch are stable while cap_valid = 1 and cap_ready = 0.
- **Reset mid-operation.** Reset discards the pending duty, the capture contents and the error flag. prev_valid = 0 suppresses a false seq_err and a false wrap on the first post-reset sample.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- pwm_out latency: 1 cycle. A count value presented at edge N is reflected in pwm_out after edge N+1.
- wrap_pulse: asserted for the single cycle following the edge at which count==0 was sampled with count_q==15. epoch updates on that same edge.
- New duty takes effect starting with the PWM period whose count==0 caused the wrap, so periods never mix old and new duty.
- Capture: cap_valid rises 1 cycle after capture_req. The handshake completes on the edge where cap_valid & cap_ready. Throughput is one capture per cycle when cap_ready is held high.
- seq_err is set 1 cycle after the offending sample.

## Test plan
- **Reset and free run.** Reset for 2 cycles, then count 0..15 repeating for 40 cycles.
  - Required: all outputs 0 during reset.
  - Required: wrap_pulse exactly at the two 15→0 transitions; epoch = 2 at the end; seq_err = 0.
- **Duty reload.** Load duty=5 mid-period.
  - Required: pwm_out stays 0 (duty_act=0) until the wrap, then exactly 5 high cycles per 16.
  - Then load duty=12 and duty=3 within one period. Required: only 3 applies at the next wrap.
- **Boundary duty.** duty=0 then duty=15.
  - Required: pwm_out constant 0 for a full period, then high 15 of 16 cycles (low only while count==15).
- **Sequence error.** Feed 3 then 5 (a skip).
  - Required: seq_err=1 one cycle later, held through 20 good cycles.
  - Pulse err_clr. Required: seq_err=0.
  - Repeat the skip simultaneously with err_clr. Required: seq_err stays 1.
- **Capture handshake.** cap_ready=0, then capture_req at count=9 with epoch=4.
  - Required: cap_valid=1, cap_count=9, cap_epoch=4.
  - Second capture_req. Required: cap_drop pulse, slot unchanged.
  - cap_ready=1 together with capture_req at count=2. Required: slot reloads with 2 and cap_valid stays 1.
- **Mid-operation reset.** Assert reset with pend_flag=1, cap_valid=1 and seq_err=1.
  - Required: all cleared next cycle.
  - Required: the first sample after reset (count=0 with count_q=0) produces neither wrap_pulse nor seq_err.

Source files
------------

// File: rtl/count_compare_pwm.sv
// Consumes the free-running 4-bit counter. Produces a period-aligned PWM, a wrap
// pulse with an epoch count, a sticky sequence-error flag and a one-slot capture register.
module count_compare_pwm #(
    parameter int EPOCH_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         count,
    input  logic [3:0]         duty,
    input  logic               duty_load,
    input  logic               err_clr,
    input  logic               capture_req,
    input  logic               cap_ready,
    output logic               pwm_out,
    output logic               wrap_pulse,
    output logic [EPOCH_W-1:0] epoch,
    output logic               seq_err,
    output logic               cap_valid,
    output logic [3:0]         cap_count,
    output logic [EPOCH_W-1:0] cap_epoch,
    output logic               cap_drop
);

    typedef enum logic {
        CAP_EMPTY = 1'b0,
        CAP_FULL  = 1'b1
    } cap_state_t;

    logic [3:0]         count_q, count_d;
    logic               prev_valid_q, prev_valid_d;
    logic [3:0]         duty_pend_q, duty_pend_d;
    logic               pend_flag_q, pend_flag_d;
    logic [3:0]         duty_act_q, duty_act_d;
    logic               pwm_q, pwm_d;
    logic               wrap_pulse_q, wrap_pulse_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic               seq_err_q, seq_err_d;

    cap_state_t         cap_state_q;
    logic [3:0]         cap_count_q;
    logic [EPOCH_W-1:0] cap_epoch_q;
    logic               cap_drop_q;

    logic               wrap;
    logic               seq_bad;
    logic [3:0]         duty_eff;

    always_comb begin
        wrap    = prev_valid_q && (count_q == 4'd15) && (count == 4'd0);
        seq_bad = prev_valid_q && (count != 4'(count_q + 4'd1));

        // The pending duty must already drive the very first cycle of the new period.
        duty_eff = (wrap && pend_flag_q) ? duty_pend_q : duty_act_q;

        count_d      = count;
        prev_valid_d = 1'b1;
        wrap_pulse_d = wrap;
        epoch_d      = epoch_q + EPOCH_W'(wrap);
        pwm_d        = (count < duty_eff);

        duty_act_d  = duty_act_q;
        duty_pend_d = duty_pend_q;
        pend_flag_d = pend_flag_q;
        if (wrap && pend_flag_q) begin
            duty_act_d  = duty_pend_q;
            pend_flag_d = 1'b0;
        end
        if (duty_load) begin
            duty_pend_d = duty;
            pend_flag_d = 1'b1;
        end

        seq_err_d = seq_err_q;
        if (seq_bad) begin
            seq_err_d = 1'b1;
        end else if (err_clr) begin
            seq_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q      <= '0;
            prev_valid_q <= 1'b0;
            duty_pend_q  <= '0;
            pend_flag_q  <= 1'b0;
            duty_act_q   <= '0;
            pwm_q        <= 1'b0;
            wrap_pulse_q <= 1'b0;
            epoch_q      <= '0;
            seq_err_q    <= 1'b0;
        end else begin
            count_q      <= count_d;
            prev_valid_q <= prev_valid_d;
            duty_pend_q  <= duty_pend_d;
            pend_flag_q  <= pend_flag_d;
            duty_act_q   <= duty_act_d;
            pwm_q        <= pwm_d;
            wrap_pulse_q <= wrap_pulse_d;
            epoch_q      <= epoch_d;
            seq_err_q    <= seq_err_d;
        end
    end

    // Capture slot; the stored epoch is the value after this cycle's wrap update.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_state_q <= CAP_EMPTY;
            cap_count_q <= '0;
            cap_epoch_q <= '0;
            cap_drop_q  <= 1'b0;
        end else begin
            cap_drop_q <= 1'b0;
            case (cap_state_q)
                CAP_EMPTY: begin
                    if (capture_req) begin
                        cap_count_q <= count;
                        cap_epoch_q <= epoch_d;
                        cap_state_q <= CAP_FULL;
                    end
                end
                CAP_FULL: begin
                    if (cap_ready) begin
                        if (capture_req) begin
                            cap_count_q <= count;
                            cap_epoch_q <= epoch_d;
                        end else begin
                            cap_state_q <= CAP_EMPTY;
                        end
                    end else if (capture_req) begin
                        cap_drop_q <= 1'b1;
                    end
                end
                default: cap_state_q <= CAP_EMPTY;
            endcase
        end
    end

    assign pwm_out    = pwm_q;
    assign wrap_pulse = wrap_pulse_q;
    assign epoch      = epoch_q;
    assign seq_err    = seq_err_q;
    assign cap_valid  = (cap_state_q == CAP_FULL);
    assign cap_count  = cap_count_q;
    assign cap_epoch  = cap_epoch_q;
    assign cap_drop   = cap_drop_q;

endmodule
